// File: rtl/axis_match_tx.sv
// axis_match_tx: packs free-running source words into fixed-length AXI4-Stream packets; define AXIS_TX_HEADER_EN to prefix each packet with a header beat
module axis_match_tx #(
  parameter int PKT_LEN    = 640,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        m_axis_aclk,
  input  logic        m_axis_areset,
  input  logic        enable,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [31:0] in_data,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        overflow,
  output logic [15:0] pkt_count,
  output logic [1:0]  state_reg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PKT_LEN + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SOF = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [33:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, last_slot, accept, wr_en, rd_en, take, hs_last, load;
  logic [33:0]   wr_data;
  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign empty     = count == '0;
  assign last_slot = cnt == CW'(PKT_LEN - 1);
  assign accept    = in_valid && (state == RUN || (state == WAIT_SOF && enable && in_sof));
  assign wr_en     = !full && (accept || state == FLUSH);
  assign wr_data   = state == FLUSH ? {2'b01, 32'h0} : {state == WAIT_SOF, state == RUN && last_slot, in_data};
  assign take      = !m_axis_tvalid || m_axis_tready;
  assign hs_last   = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign load      = take && !empty;
`ifdef AXIS_TX_HEADER_EN
  logic hdr_sent, hdr_due;
  assign hdr_due = mem[rd_ptr][33] && !hdr_sent;
  assign rd_en   = load && !hdr_due;
`else
  assign rd_en   = load;
`endif
  assign m_axis_tkeep = m_axis_tvalid ? 4'hF : 4'h0;
  assign state_reg    = state;
  // packet framing: counts input slots, drops on full FIFO, closes lost packets with a filler
  always_ff @(posedge m_axis_aclk)
    if (m_axis_areset) begin
      state    <= IDLE;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept && full) overflow <= 1'b1;
      case (state)
        IDLE:     if (enable) state <= WAIT_SOF;
        WAIT_SOF: if (!enable) state <= IDLE;
                  else if (in_valid && in_sof) begin
                    cnt   <= CW'(1);
                    state <= RUN;
                  end
        RUN:      if (in_valid) begin
                    cnt <= last_slot ? '0 : cnt + CW'(1);
                    if (last_slot) state <= full ? FLUSH : WAIT_SOF;
                  end
        FLUSH:    if (!full) state <= WAIT_SOF;
      endcase
    end
  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge m_axis_aclk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  // FIFO pointers and occupancy
  always_ff @(posedge m_axis_aclk)
    if (m_axis_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  // AXI output register, held stable until the handshake
  always_ff @(posedge m_axis_aclk)
    if (m_axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_count     <= '0;
`ifdef AXIS_TX_HEADER_EN
      hdr_sent      <= 1'b0;
`endif
    end else begin
      if (hs_last) pkt_count <= pkt_count + 16'd1;
      if (take) begin
        m_axis_tvalid <= !empty;
`ifdef AXIS_TX_HEADER_EN
        if (load) m_axis_tdata <= hdr_due ? {16'hA5A5, pkt_count + 16'(hs_last)} : mem[rd_ptr][31:0];
        if (load) hdr_sent <= hdr_due;
        m_axis_tlast  <= load && !hdr_due && mem[rd_ptr][32];
`else
        if (load) m_axis_tdata <= mem[rd_ptr][31:0];
        m_axis_tlast  <= load && mem[rd_ptr][32];
`endif
      end
    end
endmodule

// File: tb/tb_axis_match_tx.sv
// tb_axis_match_tx: directed table-driven bench for axis_match_tx (PKT_LEN=8 and an overflow instance with PKT_LEN=20)
module tb_axis_match_tx;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, en2 = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0;
  logic [31:0] in_data = '0;
  logic tready = 1'b1, tready2 = 1'b0;
  logic [31:0] tdata, tdata2;
  logic [3:0] tkeep, tkeep2;
  logic tlast, tvalid, overflow, tlast2, tvalid2, overflow2;
  logic [15:0] pkt_count, pkt_count2;
  logic [1:0] state_reg, state_reg2;
  int checks = 0, errors = 0, cyc = 0;
`ifdef AXIS_TX_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  axis_match_tx #(.PKT_LEN(8), .FIFO_DEPTH(16)) dut (
    .m_axis_aclk(clk), .m_axis_areset(rst), .enable(enable), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .overflow(overflow), .pkt_count(pkt_count),
    .state_reg(state_reg));

  axis_match_tx #(.PKT_LEN(20), .FIFO_DEPTH(16)) dut_o (
    .m_axis_aclk(clk), .m_axis_areset(rst), .enable(en2), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .m_axis_tdata(tdata2), .m_axis_tkeep(tkeep2), .m_axis_tlast(tlast2),
    .m_axis_tvalid(tvalid2), .m_axis_tready(tready2), .overflow(overflow2), .pkt_count(pkt_count2),
    .state_reg(state_reg2));

  always #5 clk = ~clk;

  typedef struct {logic v; logic sof; logic [31:0] d;} stim_t;
  typedef struct {logic [31:0] d; logic l;} beat_t;
  stim_t tab[10];
  beat_t ex[8];

  logic [31:0] q_d[$], q2_d[$], e_d[$];
  logic q_l[$], q2_l[$], e_l[$];
  logic [3:0] q_k[$];
  int q_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  // beat collector, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      q_d.push_back(tdata); q_l.push_back(tlast); q_k.push_back(tkeep); q_t.push_back(cyc);
    end
    if (!rst && tvalid2 && tready2) begin
      q2_d.push_back(tdata2); q2_l.push_back(tlast2);
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", n, got, want);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [31:0] d);
    @(posedge clk); #1;
    in_valid = v; in_sof = s; in_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic exp_pkt(input logic [31:0] off, input logic [15:0] hc);
    if (HDR != 0) begin e_d.push_back({16'hA5A5, hc}); e_l.push_back(1'b0); end
    for (int i = 0; i < 8; i++) begin e_d.push_back(ex[i].d + off); e_l.push_back(ex[i].l); end
  endtask

  task automatic cmp(input string n, input bit two, input int start);
    int got_n;
    logic [31:0] d;
    logic l;
    got_n = two ? q2_d.size() - start : q_d.size() - start;
    chk($sformatf("%s_count", n), 32'(got_n), 32'(e_d.size()));
    for (int i = 0; i < e_d.size(); i++)
      if (i < got_n) begin
        d = two ? q2_d[start+i] : q_d[start+i];
        l = two ? q2_l[start+i] : q_l[start+i];
        chk($sformatf("%s_data[%0d]", n, i), d, e_d[i]);
        chk($sformatf("%s_last[%0d]", n, i), 32'(l), 32'(e_l[i]));
        if (!two) chk($sformatf("%s_keep[%0d]", n, i), 32'(q_k[start+i]), 32'hF);
      end
    e_d.delete(); e_l.delete();
  endtask

  initial begin
    int start;
    logic stall_p;
    logic [31:0] stall_d;
    logic stall_l;
    tab[0] = '{1'b1, 1'b0, 32'hAA};
    tab[1] = '{1'b1, 1'b0, 32'hBB};
    for (int i = 0; i < 8; i++) begin
      tab[2+i] = '{1'b1, i == 0, 32'(i + 1)};
      ex[i]    = '{32'(i + 1), i == 7};
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", 32'(tkeep), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_pkt_count", 32'(pkt_count), 0);
    chk("rst_state", 32'(state_reg), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
    @(negedge clk);
    chk("idle_state", 32'(state_reg), 0);
    @(posedge clk); #1 enable = 1'b1;
    idle(2);
    @(negedge clk);
    chk("wait_sof_state", 32'(state_reg), 1);

    // basic packet with latency and throughput checks
    start = q_d.size();
    for (int i = 0; i < 8; i++) begin
      step(tab[2+i].v, tab[2+i].sof, tab[2+i].d);
      @(negedge clk);
      if (i == 1) chk("latency_n1_tvalid", 32'(tvalid), 0);
      if (i == 2) begin
        chk("latency_n2_tvalid", 32'(tvalid), 1);
        chk("latency_n2_tdata", tdata, HDR != 0 ? 32'hA5A50000 : 32'h1);
      end
    end
    idle(15);
    exp_pkt(0, 0);
    cmp("basic", 1'b0, start);
    if (q_t.size() >= start + 8 + HDR)
      chk("throughput", 32'(q_t[start+7+HDR] - q_t[start]), 32'(7 + HDR));
    else
      chk("throughput_beats", 32'(q_t.size() - start), 32'(8 + HDR));
    chk("basic_pkt_count", 32'(pkt_count), 1);
    chk("basic_overflow", 32'(overflow), 0);

    // pre-frame words without sof are discarded
    start = q_d.size();
    for (int i = 0; i < 10; i++) step(tab[i].v, tab[i].sof, tab[i].d);
    idle(15);
    exp_pkt(0, 1);
    cmp("prediscard", 1'b0, start);
    chk("prediscard_pkt_count", 32'(pkt_count), 2);

    // backpressure: tready toggles each cycle, stalled beats must hold
    start = q_d.size();
    stall_p = 1'b0; stall_d = '0; stall_l = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 8) step(tab[2+c].v, tab[2+c].sof, tab[2+c].d);
      else step(1'b0, 1'b0, 32'h0);
      tready = c[0];
      @(negedge clk);
      if (stall_p) begin
        chk("stall_tvalid", 32'(tvalid), 1);
        chk("stall_tdata", tdata, stall_d);
        chk("stall_tlast", 32'(tlast), 32'(stall_l));
      end
      stall_p = tvalid && !tready; stall_d = tdata; stall_l = tlast;
    end
    @(posedge clk); #1 tready = 1'b1;
    idle(5);
    exp_pkt(0, 2);
    cmp("backpressure", 1'b0, start);
    chk("backpressure_overflow", 32'(overflow), 0);
    chk("backpressure_pkt_count", 32'(pkt_count), 3);

    // reset mid-packet
    step(1'b1, 1'b1, 32'h11);
    for (int i = 2; i <= 4; i++) step(1'b1, 1'b0, 32'h10 + 32'(i));
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", 32'(tvalid), 0);
    chk("midrst_state", 32'(state_reg), 0);
    chk("midrst_pkt_count", 32'(pkt_count), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(3);
    start = q_d.size();
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, 32'h21 + 32'(i));
    idle(15);
    exp_pkt(32'h20, 0);
    cmp("after_reset", 1'b0, start);
    chk("after_reset_pkt_count", 32'(pkt_count), 1);

    // enable dropped mid-packet still completes the packet
    start = q_d.size();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, 32'h31 + 32'(i));
      if (i == 3) enable = 1'b0;
    end
    idle(15);
    exp_pkt(32'h30, 1);
    cmp("enable_drop", 1'b0, start);
    chk("enable_drop_pkt_count", 32'(pkt_count), 2);
    chk("enable_drop_state", 32'(state_reg), 0);

    // overflow with flush on the PKT_LEN=20 instance
    @(posedge clk); #1 en2 = 1'b1;
    idle(3);
    start = q2_d.size();
    for (int i = 1; i <= 20; i++) step(1'b1, i == 1, 32'(i));
    idle(3);
    @(negedge clk);
    chk("ovf_overflow", 32'(overflow2), 1);
    chk("ovf_state_flush", 32'(state_reg2), 3);
    @(posedge clk); #1 tready2 = 1'b1;
    idle(40);
    if (HDR != 0) begin e_d.push_back(32'hA5A50000); e_l.push_back(1'b0); end
    for (int i = 1; i <= 17 - HDR; i++) begin e_d.push_back(32'(i)); e_l.push_back(1'b0); end
    e_d.push_back(32'h0); e_l.push_back(1'b1);
    cmp("overflow", 1'b1, start);
    chk("ovf_pkt_count", 32'(pkt_count2), 1);
    chk("ovf_state_after", 32'(state_reg2), 1);
    chk("ovf_other_clean", 32'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
